// File: rtl/ysyx_25020047_ifu_pkg.sv
// ============================================================================
// Module  : ysyx_25020047_ifu_pkg
// Purpose : Shared definitions for the instruction fetch unit: FSM state
//           encoding, reset PC, instruction length and the one-hot
//           instruction-type codes shared with decode and writeback.
// Ports   : none (package)
// Config  : YSYX_25020047_IFU_PERF_EN (used by the top, not here)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_25020047_ifu_pkg;

  // Fetch FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_EXEC  = 3'd4,
    S_ERR   = 3'd5
  } ifu_state_e;

  localparam logic [31:0] C_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] C_INST_LEN = 32'd4;

  // One-hot instruction-type codes used downstream by decode/writeback.
  typedef enum logic [5:0] {
    INST_R = 6'b000001,
    INST_I = 6'b000010,
    INST_S = 6'b000100,
    INST_B = 6'b001000,
    INST_U = 6'b010000,
    INST_J = 6'b100000
  } inst_type_e;

  // Sequential next PC; wraps modulo 2^32.
  function automatic logic [31:0] f_snpc(input logic [31:0] a_pc);
    return a_pc + C_INST_LEN;
  endfunction

  // Instructions are word aligned; any low address bit set is a fault.
  function automatic logic f_misaligned(input logic [31:0] a_addr);
    return |a_addr[1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25020047_ifu_if.sv
// ============================================================================
// Module  : ysyx_25020047_ifu_if
// Purpose : Instruction-memory bus between the fetch unit (master) and the
//           memory (slave): valid/ready request channel plus a response
//           channel carrying data and an error flag.
// Signals : req_valid/req_ready/req_addr  - request channel
//           rsp_valid/rsp_data/rsp_err    - response channel
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_25020047_ifu_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_25020047_ifu_perf.sv
// ============================================================================
// Module  : ysyx_25020047_ifu_perf
// Purpose : Fetch performance counters. Both wrap at 2^32 and clear on reset.
// Ports   : clk, rst_n     - clock, asynchronous active-low reset
//           i_fetch_inc    - one completed (error-free) fetch this cycle
//           i_stall_inc    - fetch unit is requesting or waiting this cycle
//           o_fetch_cnt    - completed fetch count
//           o_stall_cnt    - request/wait cycle count
// Config  : instantiated only when YSYX_25020047_IFU_PERF_EN is defined
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25020047_ifu_perf (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_fetch_inc,
  input  wire logic        i_stall_inc,
  output logic [31:0]      o_fetch_cnt,
  output logic [31:0]      o_stall_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_stall_inc) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: rtl/ysyx_25020047_ifu.sv
// ============================================================================
// Module  : ysyx_25020047_ifu
// Purpose : Instruction fetch unit. Holds the architectural PC, fetches one
//           instruction per commit over the memory bus, hands inst/pc/snpc to
//           decode and waits for the writeback dnpc before the next fetch
//           (strictly one instruction in flight).
// Ports   : clk, rst_n              - clock, asynchronous active-low reset
//           wb_valid, wb_dnpc       - writeback commit and next PC
//           ifu_valid, ifu_ready    - decode handshake
//           inst, pc, snpc          - fetched word, its address, pc + 4
//           mem (master modport)    - instruction memory bus
//           fetch_err               - sticky bus/misalignment error
//           perf_fetch_cnt/stall    - performance counters
// Config  : YSYX_25020047_IFU_PERF_EN enables the counters; otherwise the
//           counter ports read as zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25020047_ifu
  import ysyx_25020047_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             wb_valid,
  input  wire logic [31:0]      wb_dnpc,
  output logic                  ifu_valid,
  input  wire logic             ifu_ready,
  output logic [31:0]           inst,
  output logic [31:0]           pc,
  output logic [31:0]           snpc,
  ysyx_25020047_ifu_if.master   mem,
  output logic                  fetch_err,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
);

  ifu_state_e  r_state;
  ifu_state_e  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_inst;
  logic [31:0] w_inst_nxt;
  logic        r_fetch_err;
  logic        w_fetch_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_inst      <= w_inst_nxt;
      r_fetch_err <= w_fetch_err_nxt;
    end
  end

  // Each state only looks at the inputs that belong to it, so strobes that
  // arrive in the wrong phase (rsp_valid in S_REQ, wb_valid in S_VALID, ...)
  // are dropped without any extra qualification.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_inst_nxt      = r_inst;
    w_fetch_err_nxt = r_fetch_err;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (mem.req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem.rsp_valid) begin
          if (mem.rsp_err) begin
            w_fetch_err_nxt = 1'b1;
            w_state_nxt     = S_ERR;
          end else begin
            w_inst_nxt  = mem.rsp_data;
            w_state_nxt = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (ifu_ready) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (wb_valid) begin
          // The faulting dnpc is still recorded so the offending PC is visible.
          w_pc_nxt = wb_dnpc;
          if (f_misaligned(wb_dnpc)) begin
            w_fetch_err_nxt = 1'b1;
            w_state_nxt     = S_ERR;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem.req_valid = (r_state == S_REQ);
  assign mem.req_addr  = r_pc;
  assign ifu_valid     = (r_state == S_VALID);
  assign inst          = r_inst;
  assign pc            = r_pc;
  assign snpc          = f_snpc(r_pc);
  assign fetch_err     = r_fetch_err;

`ifdef YSYX_25020047_IFU_PERF_EN
  wire w_fetch_done = (r_state == S_WAIT) && mem.rsp_valid && !mem.rsp_err;
  wire w_stall      = (r_state == S_REQ) || (r_state == S_WAIT);

  ysyx_25020047_ifu_perf u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_fetch_inc (w_fetch_done),
    .i_stall_inc (w_stall),
    .o_fetch_cnt (perf_fetch_cnt),
    .o_stall_cnt (perf_stall_cnt)
  );
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

  // Out-of-phase strobes are legal to ignore but usually point at a broken
  // neighbour, so they are flagged in simulation as warnings.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(mem.rsp_valid && (r_state != S_WAIT)))
        else $warning("ifu: rsp_valid outside S_WAIT ignored");
      assert (!(wb_valid && (r_state != S_EXEC)))
        else $warning("ifu: wb_valid outside S_EXEC ignored");
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020047_ifu.sv
// ============================================================================
// Module  : tb_ysyx_25020047_ifu
// Purpose : Self-checking bench for the instruction fetch unit: directed
//           table of fetch/commit vectors, error and reset corner sequences,
//           and a randomized fetch/commit stream checked against a
//           transaction-level model (expected PC, memory image, counters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25020047_ifu;

  localparam logic [31:0] C_RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [31:0] wb_dnpc;
  logic        ifu_valid;
  logic        ifu_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] snpc;
  logic        fetch_err;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  ysyx_25020047_ifu_if mem ();

  ysyx_25020047_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_valid       (wb_valid),
    .wb_dnpc        (wb_dnpc),
    .ifu_valid      (ifu_valid),
    .ifu_ready      (ifu_ready),
    .inst           (inst),
    .pc             (pc),
    .snpc           (snpc),
    .mem            (mem),
    .fetch_err      (fetch_err),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  typedef struct {
    logic [31:0] dnpc;
    int          rdly;
    int          sdly;
    logic [31:0] data;
    logic [31:0] exp_snpc;
  } vec_t;

  vec_t tv [5];

  // Memory image for the random stream: any fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0013_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_perf(input string tag);
`ifdef YSYX_25020047_IFU_PERF_EN
    chk({tag, "_fetch_cnt"}, perf_fetch_cnt, m_fetch);
    chk({tag, "_stall_cnt"}, perf_stall_cnt, m_stall);
`else
    chk({tag, "_fetch_cnt"}, perf_fetch_cnt, 32'h0);
    chk({tag, "_stall_cnt"}, perf_stall_cnt, 32'h0);
`endif
  endtask

  // Reset, check the reset state, release and check IDLE -> REQ timing.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_dnpc = '0; ifu_ready = 1'b0;
    mem.req_ready = 1'b0; mem.rsp_valid = 1'b0; mem.rsp_data = '0; mem.rsp_err = 1'b0;
    m_pc = C_RST_PC; m_fetch = '0; m_stall = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", {31'd0, mem.req_valid}, 32'd0);
    chk("rst_ifu_valid", {31'd0, ifu_valid}, 32'd0);
    chk("rst_pc", pc, C_RST_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk_perf("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_first_req", {31'd0, mem.req_valid}, 32'd1);
  endtask

  // One memory transaction: optional request back-pressure, optional bogus
  // response in the handshake cycle, response latency, then result checks.
  task automatic fetch(input int rdly, input int sdly, input logic [31:0] data,
                       input logic err, input logic rsp_in_hs);
    int n = 0;
    logic [31:0] exp_snpc;
    while (mem.req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_chk++; n_fail++;
      $display("FAIL req_timeout: got no req_valid expected req_valid within 20 cycles");
      return;
    end
    chk("req_addr", mem.req_addr, m_pc);
    mem.req_ready = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      m_stall++;
      @(negedge clk);
    end
    if (rdly > 0) begin
      chk("req_hold_valid", {31'd0, mem.req_valid}, 32'd1);
      chk("req_hold_addr", mem.req_addr, m_pc);
    end
    mem.req_ready = 1'b1;
    if (rsp_in_hs) begin
      mem.rsp_valid = 1'b1; mem.rsp_data = 32'hDEAD_BEEF; mem.rsp_err = 1'b0;
    end
    m_stall++;
    @(negedge clk);
    mem.req_ready = 1'b0; mem.rsp_valid = 1'b0;
    chk("req_drop", {31'd0, mem.req_valid}, 32'd0);
    for (int i = 0; i < sdly; i++) begin
      m_stall++;
      @(negedge clk);
    end
    mem.rsp_valid = 1'b1; mem.rsp_data = data; mem.rsp_err = err;
    m_stall++;
    @(negedge clk);
    mem.rsp_valid = 1'b0; mem.rsp_err = 1'b0;
    if (!err) begin
      m_fetch++;
      exp_snpc = m_pc + 32'd4;
      chk("ifu_valid", {31'd0, ifu_valid}, 32'd1);
      chk("inst", inst, data);
      chk("pc", pc, m_pc);
      chk("snpc", snpc, exp_snpc);
      chk("fetch_err_clear", {31'd0, fetch_err}, 32'd0);
    end else begin
      chk("rsp_err_fetch_err", {31'd0, fetch_err}, 32'd1);
      chk("rsp_err_ifu_valid", {31'd0, ifu_valid}, 32'd0);
    end
    chk_perf("fetch");
  endtask

  // Decode handshake; wb_same drives a stray wb_valid that must be dropped.
  task automatic accept(input int dly, input logic wb_same);
    logic [31:0] held;
    held = inst;
    ifu_ready = 1'b0;
    for (int i = 0; i < dly; i++) @(negedge clk);
    if (dly > 0) begin
      chk("dec_hold_valid", {31'd0, ifu_valid}, 32'd1);
      chk("dec_hold_inst", inst, held);
    end
    ifu_ready = 1'b1;
    if (wb_same) begin
      wb_valid = 1'b1; wb_dnpc = 32'h1234_5670;
    end
    @(negedge clk);
    ifu_ready = 1'b0; wb_valid = 1'b0;
    chk("dec_done", {31'd0, ifu_valid}, 32'd0);
  endtask

  // Writeback commit of dnpc after dly idle cycles.
  task automatic commit(input int dly, input logic [31:0] dnpc);
    for (int i = 0; i < dly; i++) @(negedge clk);
    if (dly > 0) chk("exec_no_req", {31'd0, mem.req_valid}, 32'd0);
    wb_valid = 1'b1; wb_dnpc = dnpc;
    @(negedge clk);
    wb_valid = 1'b0;
    m_pc = dnpc;
    chk("wb_pc", pc, dnpc);
    if (dnpc[1:0] == 2'b00) begin
      chk("wb_req_valid", {31'd0, mem.req_valid}, 32'd1);
      chk("wb_req_addr", mem.req_addr, dnpc);
    end else begin
      chk("mis_fetch_err", {31'd0, fetch_err}, 32'd1);
      chk("mis_req_valid", {31'd0, mem.req_valid}, 32'd0);
    end
  endtask

  initial begin
    tv[0] = '{32'h8000_0010, 0, 0, 32'h0010_0093, 32'h8000_0014};
    tv[1] = '{32'h8000_0004, 5, 1, 32'h0020_8113, 32'h8000_0008};
    tv[2] = '{32'hFFFF_FFFC, 0, 2, 32'h0000_0513, 32'h0000_0000};
    tv[3] = '{32'h0000_0000, 1, 0, 32'h00A0_0593, 32'h0000_0004};
    tv[4] = '{32'h8000_0100, 2, 3, 32'hFFF0_0613, 32'h8000_0104};

    // First fetch out of reset.
    do_reset();
    fetch(0, 0, 32'h0000_0413, 1'b0, 1'b0);
    chk("t1_inst", inst, 32'h0000_0413);
    chk("t1_snpc", snpc, 32'h8000_0004);

    // Directed table: commit, fetch, check the decode-facing values.
    for (int i = 0; i < 5; i++) begin
      accept(0, 1'b0);
      commit(0, tv[i].dnpc);
      fetch(tv[i].rdly, tv[i].sdly, tv[i].data, 1'b0, i == 3);
      chk("tbl_inst", inst, tv[i].data);
      chk("tbl_snpc", snpc, tv[i].exp_snpc);
    end

    // Randomized fetch/commit stream against the model.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      logic [31:0] nxt;
      fetch($urandom_range(0, 3), $urandom_range(0, 3), mem_word(m_pc), 1'b0,
            $urandom_range(0, 3) == 0);
      accept($urandom_range(0, 2), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) nxt = m_pc + 32'd4;
      else nxt = C_RST_PC + ({22'd0, 8'($urandom_range(0, 255)), 2'b00});
      commit($urandom_range(0, 2), nxt);
    end

    // Misaligned dnpc stops fetching.
    fetch(0, 0, mem_word(m_pc), 1'b0, 1'b0);
    accept(0, 1'b0);
    commit(1, 32'h8000_0006);
    repeat (3) @(negedge clk);
    chk("mis_still_no_req", {31'd0, mem.req_valid}, 32'd0);
    chk("mis_still_err", {31'd0, fetch_err}, 32'd1);

    // Bus error on fetch, later wb_valid ignored.
    do_reset();
    fetch(1, 1, 32'h0000_0413, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    wb_valid = 1'b1; wb_dnpc = 32'h8000_0020;
    @(negedge clk);
    wb_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_no_req", {31'd0, mem.req_valid}, 32'd0);
    chk("err_no_ifu_valid", {31'd0, ifu_valid}, 32'd0);
    chk("err_sticky", {31'd0, fetch_err}, 32'd1);
    chk("err_pc_kept", pc, C_RST_PC);
    chk_perf("err");

    // Reset while waiting for a response; late response must be ignored.
    do_reset();
    mem.req_ready = 1'b1;
    @(negedge clk);
    mem.req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", {31'd0, mem.req_valid}, 32'd0);
    chk("midrst_pc", pc, C_RST_PC);
    m_pc = C_RST_PC; m_fetch = '0; m_stall = '0;
    chk_perf("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    mem.rsp_valid = 1'b1; mem.rsp_data = 32'hBAD0_BAD0; mem.rsp_err = 1'b0;
    @(negedge clk);
    mem.rsp_valid = 1'b0;
    chk("late_rsp_ifu_valid", {31'd0, ifu_valid}, 32'd0);
    fetch(0, 0, 32'h0000_0413, 1'b0, 1'b0);
    chk("restart_inst", inst, 32'h0000_0413);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected completion before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
